// File: rtl/ddr_rd_arbiter_if.sv
// DDR read command/data port shared by the line-fetch channels.
// The master side issues commands; the slave side is the DDR controller.
interface ddr_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int DQ_WIDTH   = 32
);
    logic                    ddr_rreq;
    logic [ADDR_WIDTH-1:0]   ddr_raddr;
    logic [LEN_WIDTH-1:0]    ddr_rd_len;
    logic                    ddr_rrdy;
    logic [8*DQ_WIDTH-1:0]   ddr_rdata;
    logic                    ddr_rdata_en;
    logic                    ddr_rdone;

    modport master (
        output ddr_rreq, ddr_raddr, ddr_rd_len,
        input  ddr_rrdy, ddr_rdata, ddr_rdata_en, ddr_rdone
    );

    modport slave (
        input  ddr_rreq, ddr_raddr, ddr_rd_len,
        output ddr_rrdy, ddr_rdata, ddr_rdata_en, ddr_rdone
    );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read port among up to four line-fetch
// channels; one outstanding read, returned beats routed back to the owner.
module ddr_rd_arbiter #(
    parameter int CH_NUM     = 4,
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int DQ_WIDTH   = 32
) (
    input  logic                         ddr_clk,
    input  logic                         ddr_rst,
    input  logic [CH_NUM-1:0]            ch_rreq,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_raddr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]  ch_rd_len,
    output logic [CH_NUM-1:0]            ch_rdata_en,
    output logic [8*DQ_WIDTH-1:0]        ch_rdata,
    output logic [CH_NUM-1:0]            ch_rdone,
    output logic [CH_NUM-1:0]            ch_pending,
    output logic [CH_NUM-1:0]            ch_overrun,
    output logic                         len_err,
    output logic [1:0]                   grant_id,
    ddr_rd_arbiter_if.master             ddr
);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_WIDTH-1:0]  hold_addr [CH_NUM];
    logic [LEN_WIDTH-1:0]   hold_len  [CH_NUM];
    logic [CH_NUM-1:0]      grant_oh;
    logic [CH_NUM-1:0]      clear_vec;
    logic                   accept;
    logic                   sel_found;
    logic [1:0]             sel_idx;
    logic [2:0]             scan;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [LEN_WIDTH-1:0]   beat_cnt_d;

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            grant_oh[c] = (grant_id == 2'(c));
        end
    end

    assign accept        = (state_q == REQ) && ddr.ddr_rrdy;
    assign clear_vec     = accept ? grant_oh : '0;
    assign beat_cnt_d    = beat_cnt + LEN_WIDTH'(ddr.ddr_rdata_en);
    assign ddr.ddr_rreq  = (state_q == REQ);

    // Round-robin: first pending channel starting just after the last grant.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = grant_id;
        scan      = 3'd0;
        for (int i = 1; i <= CH_NUM; i++) begin
            scan = {1'b0, grant_id} + 3'(i);
            if (scan >= 3'(CH_NUM)) begin
                scan = scan - 3'(CH_NUM);
            end
            if (!sel_found && ch_pending[scan[1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_found)        state_d = REQ;
            REQ:     if (ddr.ddr_rrdy)     state_d = DATA;
            DATA:    if (ddr.ddr_rdone)    state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pulse landing on the cycle its pending bit is consumed is a fresh request.
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            ch_pending <= '0;
            ch_overrun <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                hold_addr[c] <= '0;
                hold_len[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (ch_rreq[c] && (!ch_pending[c] || clear_vec[c])) begin
                    hold_addr[c]  <= ch_raddr[c*ADDR_WIDTH +: ADDR_WIDTH];
                    hold_len[c]   <= ch_rd_len[c*LEN_WIDTH +: LEN_WIDTH];
                    ch_pending[c] <= 1'b1;
                end else if (ch_rreq[c]) begin
                    ch_overrun[c] <= 1'b1;
                end else if (clear_vec[c]) begin
                    ch_pending[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            grant_id       <= 2'(CH_NUM - 1);
            ddr.ddr_raddr  <= '0;
            ddr.ddr_rd_len <= '0;
            beat_cnt       <= '0;
            ch_rdata_en    <= '0;
            ch_rdata       <= '0;
            ch_rdone       <= '0;
            len_err        <= 1'b0;
        end else begin
            ch_rdata_en <= '0;
            ch_rdone    <= '0;
            if (state_q == IDLE && sel_found) begin
                grant_id       <= sel_idx;
                ddr.ddr_raddr  <= hold_addr[sel_idx];
                ddr.ddr_rd_len <= hold_len[sel_idx];
                beat_cnt       <= '0;
            end
            if (state_q == DATA) begin
                beat_cnt <= beat_cnt_d;
                if (ddr.ddr_rdata_en) begin
                    ch_rdata_en <= grant_oh;
                    ch_rdata    <= ddr.ddr_rdata;
                end
                if (ddr.ddr_rdone) begin
                    ch_rdone <= grant_oh;
                    if (beat_cnt_d != ddr.ddr_rd_len) begin
                        len_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter: table of single transfers plus
// hand-written round-robin, overrun, mid-burst reset and stray-traffic sequences.
module tb_ddr_rd_arbiter;

    localparam int CH_NUM     = 4;
    localparam int ADDR_WIDTH = 27;
    localparam int LEN_WIDTH  = 16;
    localparam int DQ_WIDTH   = 32;
    localparam int DW         = 8 * DQ_WIDTH;

    logic                         ddr_clk = 1'b0;
    logic                         ddr_rst = 1'b1;
    logic [CH_NUM-1:0]            ch_rreq = '0;
    logic [CH_NUM*ADDR_WIDTH-1:0] ch_raddr = '0;
    logic [CH_NUM*LEN_WIDTH-1:0]  ch_rd_len = '0;
    logic [CH_NUM-1:0]            ch_rdata_en;
    logic [DW-1:0]                ch_rdata;
    logic [CH_NUM-1:0]            ch_rdone;
    logic [CH_NUM-1:0]            ch_pending;
    logic [CH_NUM-1:0]            ch_overrun;
    logic                         len_err;
    logic [1:0]                   grant_id;

    int checks = 0;
    int errors = 0;

    ddr_rd_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .DQ_WIDTH(DQ_WIDTH)) ddr ();

    ddr_rd_arbiter #(
        .CH_NUM(CH_NUM), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .DQ_WIDTH(DQ_WIDTH)
    ) dut (
        .ddr_clk     (ddr_clk),
        .ddr_rst     (ddr_rst),
        .ch_rreq     (ch_rreq),
        .ch_raddr    (ch_raddr),
        .ch_rd_len   (ch_rd_len),
        .ch_rdata_en (ch_rdata_en),
        .ch_rdata    (ch_rdata),
        .ch_rdone    (ch_rdone),
        .ch_pending  (ch_pending),
        .ch_overrun  (ch_overrun),
        .len_err     (len_err),
        .grant_id    (grant_id),
        .ddr         (ddr)
    );

    always #5 ddr_clk = ~ddr_clk;

    typedef struct {
        int                    ch;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        int                    rrdy_delay;
        int                    beats;
        bit                    done_with_last;
        logic [1:0]            exp_grant;
        int                    exp_beats;
        bit                    exp_len_err;
    } vec_t;

    vec_t vecs[7];

    task automatic tick;
        @(negedge ddr_clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beatPattern(input int b, input logic [ADDR_WIDTH-1:0] a);
        logic [DW-1:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p[k*32 +: 32] = 32'hA500_0000 ^ (32'(b) << 8) ^ 32'(k) ^ {5'd0, a};
        end
        return p;
    endfunction

    task automatic setReq(input int ch, input logic [ADDR_WIDTH-1:0] addr, input logic [LEN_WIDTH-1:0] len);
        ch_raddr[ch*ADDR_WIDTH +: ADDR_WIDTH] = addr;
        ch_rd_len[ch*LEN_WIDTH +: LEN_WIDTH]  = len;
        ch_rreq[ch]                           = 1'b1;
    endtask

    task automatic applyReset;
        ddr_rst          = 1'b1;
        ch_rreq          = '0;
        ddr.ddr_rrdy     = 1'b0;
        ddr.ddr_rdata_en = 1'b0;
        ddr.ddr_rdone    = 1'b0;
        ddr.ddr_rdata    = '0;
        tick;
        tick;
        ddr_rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rreq"},     64'(ddr.ddr_rreq),   64'd0);
        checkOutput({tag, "_raddr"},    64'(ddr.ddr_raddr),  64'd0);
        checkOutput({tag, "_rd_len"},   64'(ddr.ddr_rd_len), 64'd0);
        checkOutput({tag, "_rdata_en"}, 64'(ch_rdata_en),    64'd0);
        checkOutput({tag, "_rdata"},    64'(|ch_rdata),      64'd0);
        checkOutput({tag, "_rdone"},    64'(ch_rdone),       64'd0);
        checkOutput({tag, "_pending"},  64'(ch_pending),     64'd0);
        checkOutput({tag, "_overrun"},  64'(ch_overrun),     64'd0);
        checkOutput({tag, "_len_err"},  64'(len_err),        64'd0);
        checkOutput({tag, "_grant"},    64'(grant_id),       64'd3);
    endtask

    // Bounded wait for a DDR command; the cycle count itself is compared.
    task automatic waitReq(input string tag, input int exp_wait);
        int w;
        w = 0;
        while (ddr.ddr_rreq !== 1'b1 && w < 20) begin
            tick;
            w++;
        end
        checkOutput({tag, "_wait"}, 64'(w), 64'(exp_wait));
    endtask

    task automatic runGrant(input string tag, input int exp_ch, input logic [ADDR_WIDTH-1:0] exp_addr,
                            input int exp_wait);
        int en_cnt;
        logic [CH_NUM-1:0] oh;
        oh = '0;
        oh[exp_ch] = 1'b1;
        waitReq(tag, exp_wait);
        checkOutput({tag, "_grant"}, 64'(grant_id), 64'(exp_ch));
        checkOutput({tag, "_raddr"}, 64'(ddr.ddr_raddr), 64'(exp_addr));
        ddr.ddr_rrdy = 1'b1;
        tick;
        ddr.ddr_rrdy = 1'b0;
        en_cnt = 0;
        for (int b = 0; b < 2; b++) begin
            ddr.ddr_rdata_en = 1'b1;
            ddr.ddr_rdata    = beatPattern(b, exp_addr);
            tick;
            if (ch_rdata_en == oh) en_cnt++;
        end
        ddr.ddr_rdata_en = 1'b0;
        ddr.ddr_rdone    = 1'b1;
        tick;
        ddr.ddr_rdone    = 1'b0;
        checkOutput({tag, "_beats"}, 64'(en_cnt), 64'd2);
        checkOutput({tag, "_rdone"}, 64'(ch_rdone), 64'(oh));
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int en_cnt;
        int done_cnt;
        bit data_ok;
        bit other_ok;
        bit hold_ok;
        string tag;
        logic [CH_NUM-1:0] oh;
        tag = $sformatf("vec%0d", idx);
        oh = '0;
        oh[v.ch] = 1'b1;
        applyReset;
        setReq(v.ch, v.addr, v.len);
        tick;
        ch_rreq = '0;
        checkOutput({tag, "_pending_set"}, 64'(ch_pending), 64'(oh));
        checkOutput({tag, "_rreq_t1"}, 64'(ddr.ddr_rreq), 64'd0);
        tick;
        checkOutput({tag, "_rreq_t2"}, 64'(ddr.ddr_rreq), 64'd1);
        checkOutput({tag, "_grant"}, 64'(grant_id), 64'(v.exp_grant));
        checkOutput({tag, "_raddr"}, 64'(ddr.ddr_raddr), 64'(v.addr));
        checkOutput({tag, "_rd_len"}, 64'(ddr.ddr_rd_len), 64'(v.len));
        hold_ok = 1'b1;
        repeat (v.rrdy_delay) begin
            tick;
            if (ddr.ddr_rreq !== 1'b1 || ddr.ddr_raddr !== v.addr || ddr.ddr_rd_len !== v.len)
                hold_ok = 1'b0;
        end
        checkOutput({tag, "_cmd_hold"}, 64'(hold_ok), 64'd1);
        ddr.ddr_rrdy = 1'b1;
        tick;
        ddr.ddr_rrdy = 1'b0;
        checkOutput({tag, "_rreq_drop"}, 64'(ddr.ddr_rreq), 64'd0);
        checkOutput({tag, "_pending_clr"}, 64'(ch_pending), 64'd0);

        en_cnt = 0; done_cnt = 0; data_ok = 1'b1; other_ok = 1'b1;
        for (int b = 0; b < v.beats; b++) begin
            ddr.ddr_rdata_en = 1'b1;
            ddr.ddr_rdata    = beatPattern(b, v.addr);
            ddr.ddr_rdone    = v.done_with_last && (b == v.beats - 1);
            tick;
            if (ch_rdata_en[v.ch]) en_cnt++;
            if (ch_rdata_en[v.ch] && ch_rdata !== beatPattern(b, v.addr)) data_ok = 1'b0;
            if ((ch_rdata_en & ~oh) != '0 || (ch_rdone & ~oh) != '0) other_ok = 1'b0;
            if (ch_rdone == oh) done_cnt++;
        end
        ddr.ddr_rdata_en = 1'b0;
        if (!v.done_with_last) begin
            ddr.ddr_rdone = 1'b1;
            tick;
            if (ch_rdata_en[v.ch]) en_cnt++;
            if (ch_rdone == oh) done_cnt++;
        end
        ddr.ddr_rdone = 1'b0;
        tick;
        if (ch_rdata_en[v.ch]) en_cnt++;
        if (ch_rdone != '0) done_cnt++;
        checkOutput({tag, "_beats"}, 64'(en_cnt), 64'(v.exp_beats));
        checkOutput({tag, "_data"}, 64'(data_ok), 64'd1);
        checkOutput({tag, "_other_ch"}, 64'(other_ok), 64'd1);
        checkOutput({tag, "_rdone_cnt"}, 64'(done_cnt), 64'd1);
        checkOutput({tag, "_len_err"}, 64'(len_err), 64'(v.exp_len_err));
        checkOutput({tag, "_idle"}, 64'(ddr.ddr_rreq), 64'd0);
    endtask

    initial begin
        int en_cnt;
        int stray;
        ddr.ddr_rrdy     = 1'b0;
        ddr.ddr_rdata_en = 1'b0;
        ddr.ddr_rdone    = 1'b0;
        ddr.ddr_rdata    = '0;

        //           ch  addr           len      dly beats dwl grant exp_beats err
        vecs[0] = '{1, 27'h0010000, 16'd240, 3, 240, 1'b0, 2'd1, 240, 1'b0};
        vecs[1] = '{0, 27'h7FFFFFF, 16'd1,   0, 1,   1'b1, 2'd0, 1,   1'b0};
        vecs[2] = '{3, 27'h0000000, 16'd4,   1, 4,   1'b1, 2'd3, 4,   1'b0};
        vecs[3] = '{2, 27'h1234567, 16'd0,   2, 0,   1'b0, 2'd2, 0,   1'b0};
        vecs[4] = '{1, 27'h0ABCDEF, 16'd240, 0, 239, 1'b0, 2'd1, 239, 1'b1};
        vecs[5] = '{0, 27'h0000100, 16'd3,   0, 5,   1'b0, 2'd0, 5,   1'b1};
        vecs[6] = '{3, 27'h0FFFF00, 16'd3,   0, 2,   1'b1, 2'd3, 2,   1'b1};

        applyReset;
        checkResetValues("reset");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Re-request on the acceptance cycle is queued, not an overrun.
        applyReset;
        setReq(2, 27'h0222222, 16'd2);
        tick;
        ch_rreq = '0;
        waitReq("coinc", 1);
        ddr.ddr_rrdy = 1'b1;
        setReq(2, 27'h0333333, 16'd2);
        tick;
        ddr.ddr_rrdy = 1'b0;
        ch_rreq = '0;
        checkOutput("coinc_pending", 64'(ch_pending), 64'h4);
        checkOutput("coinc_overrun", 64'(ch_overrun), 64'h0);
        ddr.ddr_rdone = 1'b1;
        tick;
        ddr.ddr_rdone = 1'b0;
        runGrant("coinc_reissue", 2, 27'h0333333, 1);
        checkOutput("coinc_overrun_end", 64'(ch_overrun), 64'h0);

        // Two pulses while pending with the command unaccepted are dropped.
        setReq(2, 27'h0444444, 16'd2);
        tick;
        setReq(2, 27'h0555555, 16'd2);
        tick;
        setReq(2, 27'h0666666, 16'd2);
        tick;
        ch_rreq = '0;
        checkOutput("ovr_flag", 64'(ch_overrun), 64'h4);
        checkOutput("ovr_pending", 64'(ch_pending), 64'h4);
        runGrant("ovr_issue", 2, 27'h0444444, 0);
        checkOutput("ovr_no_reissue", 64'(ch_pending), 64'h0);
        checkOutput("ovr_sticky", 64'(ch_overrun), 64'h4);

        // Reset at beat 100 of a 240-beat burst.
        setReq(1, 27'h0010000, 16'd240);
        tick;
        ch_rreq = '0;
        waitReq("midrst", 1);
        ddr.ddr_rrdy = 1'b1;
        tick;
        ddr.ddr_rrdy = 1'b0;
        en_cnt = 0;
        for (int b = 0; b < 100; b++) begin
            ddr.ddr_rdata_en = 1'b1;
            ddr.ddr_rdata    = beatPattern(b, 27'h0010000);
            if (b == 50) setReq(0, 27'h0000777, 16'd8);
            tick;
            ch_rreq = '0;
            if (ch_rdata_en == 4'b0010) en_cnt++;
        end
        checkOutput("midrst_beats", 64'(en_cnt), 64'd100);
        checkOutput("midrst_pending", 64'(ch_pending), 64'h1);
        ddr.ddr_rdata = beatPattern(100, 27'h0010000);
        ddr_rst = 1'b1;
        tick;
        ddr_rst = 1'b0;
        checkResetValues("midrst");
        stray = 0;
        for (int b = 101; b < 240; b++) begin
            ddr.ddr_rdata = beatPattern(b, 27'h0010000);
            tick;
            if (ch_rdata_en != '0 || ch_rdone != '0 || ddr.ddr_rreq) stray++;
        end
        ddr.ddr_rdata_en = 1'b0;
        ddr.ddr_rdone    = 1'b1;
        tick;
        ddr.ddr_rdone    = 1'b0;
        if (ch_rdata_en != '0 || ch_rdone != '0 || ddr.ddr_rreq) stray++;
        tick;
        if (ch_rdata_en != '0 || ch_rdone != '0 || ddr.ddr_rreq) stray++;
        checkOutput("midrst_stray", 64'(stray), 64'd0);

        // Round-robin with back-to-back grants.
        applyReset;
        for (int c = 0; c < 4; c++) setReq(c, 27'(32'h100 * (c + 1)), 16'd2);
        tick;
        ch_rreq = '0;
        runGrant("rr0", 0, 27'h0000100, 1);
        runGrant("rr1", 1, 27'h0000200, 1);
        runGrant("rr2", 2, 27'h0000300, 1);
        runGrant("rr3", 3, 27'h0000400, 1);
        setReq(0, 27'h0000500, 16'd2);
        setReq(2, 27'h0000600, 16'd2);
        tick;
        ch_rreq = '0;
        runGrant("rr_wrap0", 0, 27'h0000500, 1);
        runGrant("rr_wrap2", 2, 27'h0000600, 1);
        checkOutput("rr_len_err", 64'(len_err), 64'd0);

        // Data/done traffic with no read outstanding is ignored.
        stray = 0;
        tick;
        for (int b = 0; b < 3; b++) begin
            ddr.ddr_rdata_en = 1'b1;
            ddr.ddr_rdone    = 1'b1;
            ddr.ddr_rdata    = beatPattern(b, 27'h0000999);
            tick;
            if (ch_rdata_en != '0 || ch_rdone != '0 || ddr.ddr_rreq) stray++;
        end
        ddr.ddr_rdata_en = 1'b0;
        ddr.ddr_rdone    = 1'b0;
        tick;
        if (ch_rdata_en != '0 || ch_rdone != '0 || ddr.ddr_rreq) stray++;
        checkOutput("stray_outputs", 64'(stray), 64'd0);
        checkOutput("stray_len_err", 64'(len_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
